// File: rtl/intxn_pkg.sv
// Shared intersection definitions: light codes, request FSM states, fault codes.
package intxn_pkg;

  localparam logic [5:0] GNS  = 6'b100001;
  localparam logic [5:0] YNS  = 6'b010001;
  localparam logic [5:0] GEW  = 6'b001100;
  localparam logic [5:0] YEW  = 6'b001010;
  localparam logic [5:0] DARK = 6'b000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    SERVE = 2'd2
  } car_state_e;

  localparam logic [1:0] FAULT_NONE       = 2'b00;
  localparam logic [1:0] FAULT_PATTERN    = 2'b01;
  localparam logic [1:0] FAULT_TRANSITION = 2'b10;

  function automatic logic is_legal_code(input logic [5:0] code);
    return (code == GNS) || (code == YNS) || (code == GEW) || (code == YEW);
  endfunction

  // Holding a code is legal; otherwise only the forward step of the cycle is.
  function automatic logic is_legal_step(input logic [5:0] prev, input logic [5:0] cur);
    logic ok;
    ok = (cur == prev);
    case (prev)
      GNS:     ok = ok || (cur == YNS);
      YNS:     ok = ok || (cur == GEW);
      GEW:     ok = ok || (cur == YEW);
      YEW:     ok = ok || (cur == GNS);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a persistence-count debouncer.
module sync_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_raw,
  output logic level
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= sensor_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES edges in a row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      level <= 1'b0;
    end else if (sync_q2 == level) begin
      count <= '0;
    end else if (count == CNT_LAST) begin
      count <= '0;
      level <= sync_q2;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/car_request_latch.sv
// Latches debounced east/west vehicle requests for the intersection controller,
// times the wait and watches the light sequence for protocol faults.
module car_request_latch
  import intxn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned TICK_CYCLES     = 50000000,
  parameter int unsigned WAIT_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sensor_raw,
  input  logic [5:0]        lights,
  output logic              car,
  output logic [WAIT_W-1:0] wait_sec,
  output logic              fault,
  output logic [1:0]        fault_code
);

  localparam int unsigned PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

  logic             level;
  car_state_e       state;
  car_state_e       state_next;
  logic             car_next;
  logic [PRE_W-1:0] prescale;
  logic [5:0]       lights_q;
  logic [5:0]       prev_q;
  logic             pattern_err_c;
  logic             step_err_c;

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clk       (clk),
    .reset     (reset),
    .sensor_raw(sensor_raw),
    .level     (level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      car   <= 1'b0;
    end else begin
      state <= state_next;
      car   <= car_next;
    end
  end

  always_comb begin
    state_next = state;
    car_next   = 1'b0;
    case (state)
      IDLE:    if (level)         state_next = REQ;
      REQ:     if (lights == GEW) state_next = SERVE;
      SERVE:   if (lights == GNS) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    car_next = (state_next == REQ);
  end

  // Wait timer restarts on REQ entry, runs only in REQ, holds elsewhere.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale <= '0;
      wait_sec <= '0;
    end else if ((state != REQ) && (state_next == REQ)) begin
      prescale <= '0;
      wait_sec <= '0;
    end else if (state == REQ) begin
      if (prescale == PRE_LAST) begin
        prescale <= '0;
        if (wait_sec != WAIT_MAX) wait_sec <= wait_sec + WAIT_W'(1);
      end else begin
        prescale <= prescale + PRE_W'(1);
      end
    end
  end

  // prev_q == DARK stands for "no legal code seen since reset".
  always_comb begin
    pattern_err_c = 1'b0;
    step_err_c    = 1'b0;
    if (lights_q != DARK) begin
      if (!is_legal_code(lights_q)) begin
        pattern_err_c = 1'b1;
      end else if ((prev_q != DARK) && !is_legal_step(prev_q, lights_q)) begin
        step_err_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lights_q   <= DARK;
      prev_q     <= DARK;
      fault      <= 1'b0;
      fault_code <= FAULT_NONE;
    end else begin
      lights_q <= lights;
      if (is_legal_code(lights_q)) prev_q <= lights_q;
      if (!fault && (pattern_err_c || step_err_c)) begin
        fault      <= 1'b1;
        fault_code <= pattern_err_c ? FAULT_PATTERN : FAULT_TRANSITION;
      end
    end
  end

endmodule

// File: tb/tb_car_request_latch.sv
// Directed bench for car_request_latch with DEBOUNCE_CYCLES=4, TICK_CYCLES=10.
module tb_car_request_latch;
  import intxn_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       sensor_raw;
  logic [5:0] lights;
  logic       car, car2;
  logic [7:0] wait_sec;
  logic [1:0] wait2;
  logic       fault, fault2;
  logic [1:0] fault_code, code2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        sensor;
    logic [5:0]  lights;
    int unsigned cycles;
    logic        car;
    logic [7:0]  wait_s;
    logic        fault;
    logic [1:0]  code;
    string       name;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  car_request_latch #(.DEBOUNCE_CYCLES(4), .TICK_CYCLES(10), .WAIT_W(8)) dut (
    .clk(clk), .reset(reset), .sensor_raw(sensor_raw), .lights(lights),
    .car(car), .wait_sec(wait_sec), .fault(fault), .fault_code(fault_code)
  );

  car_request_latch #(.DEBOUNCE_CYCLES(4), .TICK_CYCLES(10), .WAIT_W(2)) dut2 (
    .clk(clk), .reset(reset), .sensor_raw(sensor_raw), .lights(lights),
    .car(car2), .wait_sec(wait2), .fault(fault2), .fault_code(code2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b1, GNS,  6,  1'b0, 8'd0, 1'b0, 2'b00, "press_wait"};
    vecs[1] = '{1'b1, GNS,  1,  1'b1, 8'd0, 1'b0, 2'b00, "press_car"};
    vecs[2] = '{1'b0, GNS,  24, 1'b1, 8'd2, 1'b0, 2'b00, "req_latched"};
    vecs[3] = '{1'b0, YNS,  10, 1'b1, 8'd3, 1'b0, 2'b00, "req_yns"};
    vecs[4] = '{1'b0, GEW,  1,  1'b0, 8'd3, 1'b0, 2'b00, "serve_entry"};
    vecs[5] = '{1'b0, YEW,  3,  1'b0, 8'd3, 1'b0, 2'b00, "serve_yew"};
    vecs[6] = '{1'b0, DARK, 3,  1'b0, 8'd3, 1'b0, 2'b00, "dark_gap"};
    vecs[7] = '{1'b0, GNS,  3,  1'b0, 8'd3, 1'b0, 2'b00, "back_idle"};

    reset = 1'b1;
    sensor_raw = 1'b0;
    lights = DARK;
    repeat (2) tick();
    check("rst_car", 32'(car), 32'd0);
    check("rst_wait", 32'(wait_sec), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_code", 32'(fault_code), 32'd0);
    reset = 1'b0;

    // Clean press and full serve cycle
    foreach (vecs[i]) begin
      sensor_raw = vecs[i].sensor;
      lights = vecs[i].lights;
      repeat (vecs[i].cycles) tick();
      check({vecs[i].name, "_car"}, 32'(car), 32'(vecs[i].car));
      check({vecs[i].name, "_wait"}, 32'(wait_sec), 32'(vecs[i].wait_s));
      check({vecs[i].name, "_wait2"}, 32'(wait2), 32'(vecs[i].wait_s));
      check({vecs[i].name, "_fault"}, 32'(fault), 32'(vecs[i].fault));
      check({vecs[i].name, "_code"}, 32'(fault_code), 32'(vecs[i].code));
    end

    // Bounce: 2-cycle toggling never survives debounce
    for (int i = 0; i < 10; i++) begin
      sensor_raw = ~sensor_raw;
      tick();
      check("bounce_car", 32'(car), 32'd0);
      tick();
      check("bounce_car", 32'(car), 32'd0);
    end
    sensor_raw = 1'b0;
    repeat (8) tick();
    check("bounce_after", 32'(car), 32'd0);

    // Three-cycle pulse is one short of acceptance
    sensor_raw = 1'b1;
    repeat (3) tick();
    sensor_raw = 1'b0;
    repeat (8) tick();
    check("pulse3_car", 32'(car), 32'd0);

    // Four-cycle pulse is accepted and latched after the sensor drops
    sensor_raw = 1'b1;
    repeat (4) tick();
    sensor_raw = 1'b0;
    repeat (2) tick();
    check("pulse4_early", 32'(car), 32'd0);
    tick();
    check("pulse4_car", 32'(car), 32'd1);
    check("pulse4_wait", 32'(wait_sec), 32'd0);
    repeat (25) tick();
    check("sat_wait_mid", 32'(wait_sec), 32'd2);
    check("sat_wait2_mid", 32'(wait2), 32'd2);
    repeat (35) tick();
    check("sat_wait", 32'(wait_sec), 32'd6);
    check("sat_wait2", 32'(wait2), 32'd3);
    check("sat_car", 32'(car), 32'd1);

    // Asynchronous reset in REQ with the sensor held high
    sensor_raw = 1'b1;
    repeat (2) tick();
    check("prerst_car", 32'(car), 32'd1);
    #3 reset = 1'b1;
    #1;
    check("arst_car", 32'(car), 32'd0);
    check("arst_wait", 32'(wait_sec), 32'd0);
    check("arst_wait2", 32'(wait2), 32'd0);
    check("arst_car2", 32'(car2), 32'd0);
    tick();
    reset = 1'b0;
    repeat (6) tick();
    check("rerq_early", 32'(car), 32'd0);
    tick();
    check("rerq_car", 32'(car), 32'd1);
    check("rerq_wait", 32'(wait_sec), 32'd0);

    // GNS directly to GEW is an illegal transition
    lights = GEW;
    tick();
    check("trans_fault_lag", 32'(fault), 32'd0);
    check("trans_serve_car", 32'(car), 32'd0);
    tick();
    check("trans_fault", 32'(fault), 32'd1);
    check("trans_code", 32'(fault_code), 32'd2);
    lights = 6'b111111;
    repeat (3) tick();
    check("sticky_fault", 32'(fault), 32'd1);
    check("first_code", 32'(fault_code), 32'd2);

    // After reset an illegal pattern reports 01
    reset = 1'b1;
    repeat (2) tick();
    check("rst2_fault", 32'(fault), 32'd0);
    check("rst2_code", 32'(fault_code), 32'd0);
    reset = 1'b0;
    tick();
    check("pat_fault_lag", 32'(fault), 32'd0);
    tick();
    check("pat_fault", 32'(fault), 32'd1);
    check("pat_code", 32'(fault_code), 32'd1);
    check("pat_code2", 32'(code2), 32'd1);
    check("pat_fault2", 32'(fault2), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
